tcdm_bank_responder: RTL and testbench

- Single-bank TCDM slave that services the XBAR_TCDM_BUS-style master ports driven by HWPE engines (req/gnt/add/wen/be/wdata out, r_rdata/r_valid back).
- Round-robin arbitrates N_PORTS masters onto one word-wide storage array. Grants at most one request per cycle. Returns the read or write response exactly one cycle after the grant.
- Used as the responder end for HWPE TCDM ports in standalone subsystem benches, and as a small scratch bank in the cluster.

---
 rtl/tcdm_bank_responder.sv | 108 ++++++++++
 tb/tb_tcdm_bank_responder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcdm_bank_responder.sv
// Single-bank TCDM responder: round-robin arbitration of N_PORTS masters onto one
// word-wide storage array, with a registered response exactly one cycle after grant.
module tcdm_bank_responder #(
    parameter int unsigned N_PORTS  = 4,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_LSB = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  logic [N_PORTS-1:0]         req_i,
    output logic [N_PORTS-1:0]         gnt_o,
    input  logic [N_PORTS-1:0][31:0]   add_i,
    input  logic [N_PORTS-1:0]         wen_i,
    input  logic [N_PORTS-1:0][3:0]    be_i,
    input  logic [N_PORTS-1:0][31:0]   wdata_i,
    output logic [N_PORTS-1:0][31:0]   r_rdata_o,
    output logic [N_PORTS-1:0]         r_valid_o,
    output logic                       busy_o
);
    localparam int unsigned PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int unsigned AW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    logic          gnt_any;
    logic          resp_vld_q;
    logic [PW-1:0] resp_port_q;
    logic [31:0]   resp_data_q;
    logic [31:0]   mem_q [DEPTH];

    logic [31:0]   sel_add;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_be;
    logic          sel_wen;
    logic [AW-1:0] idx;
    logic          unused_add_bits;

    // Search starts at the pointer and wraps; the first requester found wins.
    always_comb begin
        int j;
        gnt_o   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        if (!rst && !stall_i) begin
            for (int i = 0; i < int'(N_PORTS); i++) begin
                j = int'(ptr_q) + i;
                if (j >= int'(N_PORTS)) j = j - int'(N_PORTS);
                if (!gnt_any && req_i[j]) begin
                    gnt_any  = 1'b1;
                    gnt_idx  = PW'(j);
                    gnt_o[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_idx == PW'(N_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
    end

    assign sel_add   = add_i[gnt_idx];
    assign sel_wdata = wdata_i[gnt_idx];
    assign sel_be    = be_i[gnt_idx];
    assign sel_wen   = wen_i[gnt_idx];
    assign idx       = sel_add[ADDR_LSB +: AW];
    // Address bits outside the word index are intentionally ignored (aliasing).
    assign unused_add_bits = ^sel_add;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            resp_vld_q  <= 1'b0;
            resp_port_q <= '0;
            resp_data_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            resp_vld_q  <= gnt_any;
            resp_port_q <= gnt_idx;
            resp_data_q <= (gnt_any && sel_wen) ? mem_q[idx] : '0;
        end
    end

    // Storage is not reset; gnt_any is already low during reset.
    always_ff @(posedge clk) begin
        if (gnt_any && !sel_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_be[b]) mem_q[idx][8*b +: 8] <= sel_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        r_valid_o = '0;
        r_rdata_o = '0;
        for (int k = 0; k < int'(N_PORTS); k++) begin
            if (resp_vld_q && (resp_port_q == PW'(k))) begin
                r_valid_o[k] = 1'b1;
                r_rdata_o[k] = resp_data_q;
            end
        end
    end

    assign busy_o = (|req_i) | resp_vld_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Bench for tcdm_bank_responder: per-scenario tasks with inline checks, plus a
// scoreboard of expected responses pushed at each edge and popped one cycle later.
module tb_tcdm_bank_responder;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic [NP-1:0] req = '0, wen = '0, gnt, rvalid;
    logic busy;
    logic [NP-1:0][31:0] add = '0, wdata = '0, rdata;
    logic [NP-1:0][3:0] be = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tcdm_bank_responder #(.N_PORTS(NP), .DEPTH(256), .ADDR_LSB(2)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .req_i(req), .gnt_o(gnt),
        .add_i(add), .wen_i(wen), .be_i(be), .wdata_i(wdata),
        .r_rdata_o(rdata), .r_valid_o(rvalid), .busy_o(busy)
    );

    typedef struct {
        bit          vld;
        int          port;
        logic [31:0] data;
        bit          dc;
    } resp_t;

    resp_t       sbq[$];
    int          mptr = 0;
    logic [31:0] mmem [int];

    function automatic int model_port();
        if (rst || stall) return -1;
        for (int i = 0; i < NP; i++) begin
            if (req[(mptr + i) % NP]) return (mptr + i) % NP;
        end
        return -1;
    endfunction

    // Reference model: decides the grant at each edge and queues the response due next cycle.
    always @(posedge clk) begin
        resp_t e;
        int p, w;
        logic [31:0] nw;
        e.vld = 1'b0; e.port = 0; e.data = '0; e.dc = 1'b0;
        p = model_port();
        if (rst) mptr = 0;
        else if (p >= 0) begin
            w = int'(add[p][9:2]);
            e.vld = 1'b1;
            e.port = p;
            if (wen[p]) begin
                if (mmem.exists(w)) e.data = mmem[w];
                else e.dc = 1'b1;
            end else if (be[p] == 4'hF || mmem.exists(w)) begin
                nw = mmem.exists(w) ? mmem[w] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (be[p][b]) nw[8*b +: 8] = wdata[p][8*b +: 8];
                mmem[w] = nw;
            end
            mptr = (p + 1) % NP;
        end
        sbq.push_back(e);
    end

    always @(negedge clk) begin
        resp_t e;
        int p;
        logic [NP-1:0] eg;
        logic ev;
        logic [31:0] ed;
        p = model_port();
        eg = '0;
        if (p >= 0) eg[p] = 1'b1;
        total++;
        if (gnt !== eg) begin
            bad++;
            $display("FAIL sb_gnt t=%0t got=%b exp=%b", $time, gnt, eg);
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int k = 0; k < NP; k++) begin
                ev = e.vld && (e.port == k);
                ed = ev ? e.data : 32'h0;
                total++;
                if (rvalid[k] !== ev) begin
                    bad++;
                    $display("FAIL sb_rvalid[%0d] t=%0t got=%b exp=%b", k, $time, rvalid[k], ev);
                end
                if (!(ev && e.dc)) begin
                    total++;
                    if (rdata[k] !== ed) begin
                        bad++;
                        $display("FAIL sb_rdata[%0d] t=%0t got=%h exp=%h", k, $time, rdata[k], ed);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'hF; wen = 4'hF;
        tick(); tick();
        #1;
        total++;
        if (gnt !== 4'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0); end
        total++;
        if (rvalid !== 4'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=%b", rvalid, 4'b0); end
        total++;
        if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        req = '0;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        req = 4'b0001; wen = 4'b0000; add[0] = 32'h10; wdata[0] = 32'hDEADBEEF; be[0] = 4'hF;
        #2;
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL wr_gnt got=%b exp=0001", gnt); end
        tick();
        wen = 4'b0001;
        #2;
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL rd_gnt got=%b exp=0001", gnt); end
        total++;
        if (rvalid !== 4'b0001) begin bad++; $display("FAIL wr_rvalid got=%b exp=0001", rvalid); end
        total++;
        if (rdata[0] !== 32'h0) begin bad++; $display("FAIL wr_rdata got=%h exp=0", rdata[0]); end
        tick();
        req = '0;
        #2;
        total++;
        if (rvalid !== 4'b0001) begin bad++; $display("FAIL rd_rvalid got=%b exp=0001", rvalid); end
        total++;
        if (rdata[0] !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%h exp=deadbeef", rdata[0]); end
        tick();
        #2;
        total++;
        if (rvalid !== 4'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL idle_after_rd rvalid=%b busy=%b exp 0000/0", rvalid, busy);
        end
    endtask

    task automatic test_byte_enable();
        req = 4'b0010; wen = 4'b0000; add[1] = 32'h20; wdata[1] = 32'h11223344; be[1] = 4'hF;
        tick();
        wdata[1] = 32'hAABBCCDD; be[1] = 4'b0101;
        tick();
        wen = 4'b0010;
        tick();
        req = '0;
        #2;
        total++;
        if (rvalid !== 4'b0010) begin bad++; $display("FAIL be_rvalid got=%b exp=0010", rvalid); end
        total++;
        if (rdata[1] !== 32'h11BB33DD) begin bad++; $display("FAIL be_rdata got=%h exp=11bb33dd", rdata[1]); end
        tick();
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] eg, prev;
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0; wen = 4'hF;
        for (int k = 0; k < NP; k++) add[k] = 32'h10;
        req = 4'hF;
        prev = '0;
        for (int i = 0; i < 8; i++) begin
            eg = '0;
            eg[i % NP] = 1'b1;
            #2;
            total++;
            if (gnt !== eg) begin bad++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt, eg); end
            if (i > 0) begin
                total++;
                if (rvalid !== prev) begin bad++; $display("FAIL rr_rvalid[%0d] got=%b exp=%b", i, rvalid, prev); end
            end
            prev = eg;
            tick();
        end
        req = '0;
        #2;
        total++;
        if (rvalid !== 4'b1000) begin bad++; $display("FAIL rr_last_rvalid got=%b exp=1000", rvalid); end
        tick();
    endtask

    task automatic test_stall();
        req = 4'b0010; wen = 4'hF;
        tick();
        req = '0;
        tick();
        stall = 1'b1; req = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++;
            if (gnt !== 4'b0 || rvalid !== 4'b0) begin
                bad++; $display("FAIL stall[%0d] gnt=%b rvalid=%b exp 0000/0000", i, gnt, rvalid);
            end
            tick();
        end
        stall = 1'b0;
        #2;
        total++;
        if (gnt !== 4'b0100 || rvalid !== 4'b0) begin
            bad++; $display("FAIL stall_release gnt=%b rvalid=%b exp 0100/0000", gnt, rvalid);
        end
        tick();
        req = '0;
        #2;
        total++;
        if (rvalid !== 4'b0100) begin bad++; $display("FAIL stall_resp got=%b exp=0100", rvalid); end
        tick();
    endtask

    task automatic test_alias();
        req = 4'b1000; wen = 4'b0000; add[3] = 32'h400; wdata[3] = 32'h55; be[3] = 4'hF;
        tick();
        wen = 4'b1000; add[3] = 32'h0;
        tick();
        req = '0;
        #2;
        total++;
        if (rvalid !== 4'b1000 || rdata[3] !== 32'h55) begin
            bad++; $display("FAIL alias rvalid=%b rdata=%h exp 1000/00000055", rvalid, rdata[3]);
        end
        tick();
    endtask

    task automatic test_reset_pending();
        req = 4'b0100; wen = 4'b0100; add[2] = 32'h10;
        tick();
        rst = 1'b1; req = 4'b0001; wen = 4'b0000;
        add[0] = 32'h10; wdata[0] = 32'hBAD0BAD0; be[0] = 4'hF;
        #2;
        total++;
        if (gnt !== 4'b0 || rvalid !== 4'b0100) begin
            bad++; $display("FAIL rstp_cycle gnt=%b rvalid=%b exp 0000/0100", gnt, rvalid);
        end
        tick();
        rst = 1'b0; req = 4'hF; wen = 4'hF;
        for (int k = 0; k < NP; k++) add[k] = 32'h10;
        #2;
        total++;
        if (rvalid !== 4'b0) begin bad++; $display("FAIL rstp_rvalid got=%b exp=0000", rvalid); end
        total++;
        if (gnt !== 4'b0001) begin bad++; $display("FAIL rstp_gnt got=%b exp=0001", gnt); end
        tick();
        req = '0;
        #2;
        total++;
        if (rvalid !== 4'b0001 || rdata[0] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rstp_nowrite rvalid=%b rdata=%h exp 0001/deadbeef", rvalid, rdata[0]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_round_robin();
        test_stall();
        test_alias();
        test_reset_pending();
        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
